// File: rtl/tcoder_ctrl_pkg.sv
// Shared transform-coding definitions: QP limits, stage indices and the per-stage record.
package tcoder_ctrl_pkg;

    localparam int unsigned QP_W      = 6;
    localparam int unsigned QP_BY6_W  = 4;
    localparam int unsigned QP_MOD6_W = 3;
    localparam int unsigned TAG_MAX_W = 32;
    localparam int unsigned BLK_CNT_W = 16;

    localparam logic [QP_W-1:0] QP_MAX = QP_W'(51);

    // Pipeline order: forward transform, forward quantize, inverse quantize, inverse transform.
    localparam int unsigned STG_FT = 0;
    localparam int unsigned STG_FQ = 1;
    localparam int unsigned STG_IQ = 2;
    localparam int unsigned STG_IT = 3;

    // Tag field is sized for the widest supported TAG_W; the top uses the low TAG_W bits.
    typedef struct packed {
        logic                  valid;
        logic [TAG_MAX_W-1:0]  tag;
        logic [QP_W-1:0]       qp;
        logic [QP_BY6_W-1:0]   qp_by6;
        logic [QP_MOD6_W-1:0]  qp_mod6;
    } tc_stage_t;

endpackage

// File: rtl/tcoder_ctrl_if.sv
// Block-issue and reconstructed-block handshakes between residual source, controller and sink.
interface tcoder_ctrl_if
    import tcoder_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [QP_W-1:0]  in_qp;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [QP_W-1:0]  out_qp;

    modport master (
        output in_valid, in_qp, in_tag, out_ready,
        input  in_ready, out_valid, out_tag, out_qp
    );

    modport slave (
        input  in_valid, in_qp, in_tag, out_ready,
        output in_ready, out_valid, out_tag, out_qp
    );

endinterface

// File: rtl/tc_qp_split.sv
// Clamps QP to QP_MAX and splits it into QP/6 and QP%6 (purely combinational).
module tc_qp_split
    import tcoder_ctrl_pkg::*;
(
    input  logic [QP_W-1:0]      qp_i,
    output logic [QP_W-1:0]      qp_o,
    output logic [QP_BY6_W-1:0]  by6_o,
    output logic [QP_MOD6_W-1:0] mod6_o
);

    logic [11:0] prod_c;

    // x*43>>8 equals x/6 exactly for every x in 0..51
    always_comb begin
        qp_o   = (qp_i > QP_MAX) ? QP_MAX : qp_i;
        prod_c = 12'(qp_o) * 12'd43;
        by6_o  = QP_BY6_W'(prod_c >> 8);
        mod6_o = QP_MOD6_W'(qp_o - QP_W'(by6_o) * QP_W'(6));
    end

endmodule

// File: rtl/tcoder_ctrl.sv
// 4x4 transform-coding pipeline sequencer: per-stage valid/tag/QP tracking with
// elastic backpressure, flush, and a completed-block counter.
module tcoder_ctrl
    import tcoder_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned TAG_W      = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    tcoder_ctrl_if.slave          bus,
    input  logic                  flush,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [QP_BY6_W-1:0]   q_qp_by6,
    output logic [QP_MOD6_W-1:0]  q_qp_mod6,
    output logic [QP_BY6_W-1:0]   iq_qp_by6,
    output logic [QP_MOD6_W-1:0]  iq_qp_mod6,
    output logic                  busy,
    output logic [BLK_CNT_W-1:0]  blk_count
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    tc_stage_t stg_q [NUM_STAGES];
    tc_stage_t stg_d [NUM_STAGES];

    logic [NUM_STAGES-1:0] vld_c;
    logic [NUM_STAGES-1:0] able_c;
    logic [NUM_STAGES-1:0] en_c;
    logic                  rdy_c;
    logic                  accept_c;
    logic                  out_hs_c;
    logic [QP_W-1:0]       qp_clamp_c;
    logic [QP_BY6_W-1:0]   qp_by6_c;
    logic [QP_MOD6_W-1:0]  qp_mod6_c;
    logic [BLK_CNT_W-1:0]  blk_count_q;
    logic                  stg_last_unused;

    tc_qp_split u_qp_split (
        .qp_i   (bus.in_qp),
        .qp_o   (qp_clamp_c),
        .by6_o  (qp_by6_c),
        .mod6_o (qp_mod6_c)
    );

    // Stage k can move unless it and every stage after it is full with the sink stalled.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        assign vld_c[k]  = stg_q[k].valid;
        assign able_c[k] = bus.out_ready || !(&vld_c[LAST:k]);
    end

    always_comb begin
        rdy_c    = able_c[0] && !flush;
        accept_c = bus.in_valid && rdy_c;
        en_c     = '0;
        en_c[0]  = accept_c;
        for (int k = 1; k < NUM_STAGES; k++) begin
            en_c[k] = vld_c[k-1] && able_c[k] && !flush;
        end
    end

    always_comb begin
        stg_d = stg_q;
        if (flush) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg_d[k].valid = 1'b0;
            end
        end else begin
            if (able_c[0]) begin
                stg_d[0].valid = accept_c;
                if (accept_c) begin
                    stg_d[0].tag     = TAG_MAX_W'(bus.in_tag);
                    stg_d[0].qp      = qp_clamp_c;
                    stg_d[0].qp_by6  = qp_by6_c;
                    stg_d[0].qp_mod6 = qp_mod6_c;
                end
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (able_c[k]) begin
                    if (vld_c[k-1]) begin
                        stg_d[k] = stg_q[k-1];
                    end else begin
                        stg_d[k].valid = 1'b0;
                    end
                end
            end
        end
    end

    assign out_hs_c = vld_c[LAST] && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg_q[k] <= '0;
            end
            blk_count_q <= '0;
        end else begin
            stg_q <= stg_d;
            if (out_hs_c) begin
                blk_count_q <= blk_count_q + BLK_CNT_W'(1);
            end
        end
    end

    // Ready and the accept enable are masked while reset is held so nothing looks live.
    assign bus.in_ready  = rdy_c && reset;
    assign stage_en      = reset ? en_c : '0;
    assign bus.out_valid = vld_c[LAST];
    assign bus.out_tag   = stg_q[LAST].tag[TAG_W-1:0];
    assign bus.out_qp    = stg_q[LAST].qp;
    assign q_qp_by6      = stg_q[STG_FT].qp_by6;
    assign q_qp_mod6     = stg_q[STG_FT].qp_mod6;
    assign iq_qp_by6     = stg_q[STG_FQ].qp_by6;
    assign iq_qp_mod6    = stg_q[STG_FQ].qp_mod6;
    assign busy          = |vld_c;
    assign blk_count     = blk_count_q;

    assign stg_last_unused = ^{stg_q[LAST].tag, stg_q[LAST].qp_by6, stg_q[LAST].qp_mod6};

endmodule

// File: tb/tb_tcoder_ctrl.sv
// Directed bench for tcoder_ctrl: latency walk, QP clamp, streaming, backpressure, flush, async reset.
module tb_tcoder_ctrl;
    import tcoder_ctrl_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned TW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [NS-1:0]        stage_en;
    logic [QP_BY6_W-1:0]  q_qp_by6;
    logic [QP_MOD6_W-1:0] q_qp_mod6;
    logic [QP_BY6_W-1:0]  iq_qp_by6;
    logic [QP_MOD6_W-1:0] iq_qp_mod6;
    logic                 busy;
    logic [BLK_CNT_W-1:0] blk_count;

    tcoder_ctrl_if #(.TAG_W(TW)) bus ();

    tcoder_ctrl #(.NUM_STAGES(NS), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush      (flush),
        .stage_en   (stage_en),
        .q_qp_by6   (q_qp_by6),
        .q_qp_mod6  (q_qp_mod6),
        .iq_qp_by6  (iq_qp_by6),
        .iq_qp_mod6 (iq_qp_mod6),
        .busy       (busy),
        .blk_count  (blk_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    logic [13:0] exp_q [$];

    logic [5:0] t2_qp   [4] = '{6'd63, 6'd52, 6'd0, 6'd47};
    logic [5:0] t2_eqp  [4] = '{6'd51, 6'd51, 6'd0, 6'd47};
    logic [3:0] t2_by6  [4] = '{4'd8,  4'd8,  4'd0, 4'd7};
    logic [2:0] t2_mod6 [4] = '{3'd3,  3'd3,  3'd0, 3'd5};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scores any output handshake against the expected queue, then advances one clock.
    task automatic tick();
        logic [13:0] e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_tag", 32'(bus.out_tag), 32'(e[13:6]));
                chk("out_qp",  32'(bus.out_qp),  32'(e[5:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_qp = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stage_en",  32'(stage_en),      32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_blk_count", 32'(blk_count),     32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // single block, qp=28
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_qp = 6'd28; bus.in_tag = 8'h11;
        #1;
        chk("t1_en0", 32'(stage_en), 32'h1);
        chk("t1_rdy", 32'(bus.in_ready), 32'd1);
        exp_q.push_back({8'h11, 6'd28});
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_en1",   32'(stage_en),  32'h2);
        chk("t1_q_by6", 32'(q_qp_by6),  32'd4);
        chk("t1_q_mod", 32'(q_qp_mod6), 32'd4);
        chk("t1_oval1", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        chk("t1_en2",    32'(stage_en),   32'h4);
        chk("t1_iq_by6", 32'(iq_qp_by6),  32'd4);
        chk("t1_iq_mod", 32'(iq_qp_mod6), 32'd4);
        tick();
        #1;
        chk("t1_en3", 32'(stage_en), 32'h8);
        tick();
        #1;
        chk("t1_oval4", 32'(bus.out_valid), 32'd1);
        chk("t1_otag4", 32'(bus.out_tag),   32'h11);
        tick();
        #1;
        chk("t1_cnt",   32'(blk_count),     32'd1);
        chk("t1_oval5", 32'(bus.out_valid), 32'd0);
        chk("t1_busy",  32'(busy),          32'd0);

        // QP clamp and div/mod 6 table, back to back
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_qp = t2_qp[i]; bus.in_tag = 8'(8'h20 + i);
            exp_q.push_back({bus.in_tag, t2_eqp[i]});
            tick();
            chk("t2_q_by6", 32'(q_qp_by6),  32'(t2_by6[i]));
            chk("t2_q_mod", 32'(q_qp_mod6), 32'(t2_mod6[i]));
            if (i > 0) chk("t2_iq_by6", 32'(iq_qp_by6), 32'(t2_by6[i-1]));
        end
        bus.in_valid = 1'b0;
        repeat (6) tick();
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        chk("t2_cnt",   32'(blk_count),    32'd5);

        // 8 back-to-back blocks
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_qp = 6'd10; bus.in_tag = 8'(i);
            #1;
            chk("t3_rdy",  32'(bus.in_ready),  32'd1);
            chk("t3_oval", 32'(bus.out_valid), (i >= 4) ? 32'd1 : 32'd0);
            exp_q.push_back({8'(i), 6'd10});
            tick();
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t3_oval_tail", 32'(bus.out_valid), 32'd1);
            tick();
        end
        #1;
        chk("t3_oval_end", 32'(bus.out_valid), 32'd0);
        chk("t3_drain",    32'(exp_q.size()),  32'd0);
        chk("t3_cnt",      32'(blk_count),     32'd13);

        // sink stalled with 5 blocks offered
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1; bus.in_qp = 6'd20;
            bus.in_tag = (c < 4) ? 8'(8'h30 + c) : 8'h34;
            #1;
            chk("t4_rdy", 32'(bus.in_ready), (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) exp_q.push_back({bus.in_tag, 6'd20});
            if (c >= 4) begin
                chk("t4_oval", 32'(bus.out_valid), 32'd1);
                chk("t4_otag", 32'(bus.out_tag),   32'h30);
                chk("t4_oqp",  32'(bus.out_qp),    32'd20);
                chk("t4_en",   32'(stage_en),      32'd0);
            end
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (6) tick();
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        chk("t4_cnt",   32'(blk_count),    32'd17);

        // flush with 3 blocks in flight and a block offered
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_qp = 6'd5; bus.in_tag = 8'(8'h40 + i);
            tick();
        end
        bus.in_tag = 8'h43; flush = 1'b1;
        #1;
        chk("t5_rdy",  32'(bus.in_ready), 32'd0);
        chk("t5_en",   32'(stage_en),     32'd0);
        chk("t5_busy", 32'(busy),         32'd1);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("t5_busy_after", 32'(busy), 32'd0);
        for (int j = 0; j < 5; j++) begin
            chk("t5_noout", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("t5_cnt", 32'(blk_count), 32'd17);

        // async reset mid-stream
        bus.in_valid = 1'b1; bus.in_qp = 6'd30; bus.in_tag = 8'h50;
        tick();
        bus.in_tag = 8'h51;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("t6_oval_pre", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_oval",  32'(bus.out_valid), 32'd0);
        chk("t6_busy",  32'(busy),          32'd0);
        chk("t6_en",    32'(stage_en),      32'd0);
        chk("t6_rdy",   32'(bus.in_ready),  32'd0);
        chk("t6_cnt",   32'(blk_count),     32'd0);
        chk("t6_otag",  32'(bus.out_tag),   32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_qp = 6'd12; bus.in_tag = 8'h60;
        exp_q.push_back({8'h60, 6'd12});
        #1;
        chk("t6_en0", 32'(stage_en), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        for (int j = 1; j < 4; j++) begin
            #1;
            chk("t6_lat_wait", 32'(bus.out_valid), 32'd0);
            tick();
        end
        #1;
        chk("t6_lat_oval", 32'(bus.out_valid), 32'd1);
        chk("t6_lat_otag", 32'(bus.out_tag),   32'h60);
        tick();
        #1;
        chk("t6_cnt_end", 32'(blk_count),    32'd1);
        chk("t6_drain",   32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tcoder_ctrl.md
TCODER_CTRL -- requirements
Module: tcoder_ctrl

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 4: pipeline stages sequenced, in order forward transform, forward quantize, inverse quantize, inverse transform.
REQ-002 SHALL provide parameter TAG_W, default 8: width of the block tag carried alongside each 4x4 block.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide ports in_valid (input, 1), in_ready (output, 1), in_qp (input, 6), in_tag (input, TAG_W): block-issue handshake from the residual source.
REQ-006 SHALL provide port stage_en, output, NUM_STAGES bits: per-stage load enable to the transform datapath.
REQ-007 SHALL provide ports q_qp_by6 (output, 4), q_qp_mod6 (output, 3), iq_qp_by6 (output, 4), iq_qp_mod6 (output, 3): QP terms for the quantize and inverse-quantize stages.
REQ-008 SHALL provide ports out_valid (output, 1), out_ready (input, 1), out_tag (output, TAG_W), out_qp (output, 6): reconstructed-block handshake.
REQ-009 SHALL provide ports flush (input, 1), busy (output, 1), blk_count (output, 16): synchronous pipeline clear, any-stage-occupied flag, and completed-block count.

Function
REQ-010 SHALL hold per-stage state: valid bit, tag, clamped QP, QP/6, QP%6.
REQ-011 SHALL accept a block when in_valid and in_ready are both high on a rising edge.
REQ-012 SHALL clamp in_qp above 51 to 51 at acceptance; QP/6 and QP%6 are computed from the clamped value and stored in stage 0.
REQ-013 SHALL define stage k as able to move when stage k is empty or stage k+1 is able to move; the last stage is able to move when it is empty or out_ready is high.
REQ-014 SHALL drive in_ready = stage 0 able to move and flush low.
REQ-015 SHALL assert stage_en[0] in the cycle a block is accepted, and stage_en[k] (k>0) in the cycle stage k-1 is valid and stage k is able to move.
REQ-016 SHALL drive q_qp_* from the stage feeding the quantize stage (stage 0) and iq_qp_* from the stage feeding inverse quantize (stage 1), so each enable sees its own block's QP.
REQ-017 SHALL clear a stage's valid bit when it moves and no block enters it.
REQ-018 SHALL drive out_valid = last-stage valid, with out_tag and out_qp from that stage; out_tag and out_qp remain stable while out_valid is high and out_ready is low.
REQ-019 SHALL give latency NUM_STAGES cycles from acceptance to out_valid, with throughput one block per cycle when out_ready stays high.
REQ-020 SHALL increment blk_count on each out_valid and out_ready handshake, wrapping 0xFFFF to 0x0000.
REQ-021 SHALL clear all valid bits and force stage_en to 0 on flush; flush wins over a simultaneous accept, and blk_count is not changed by flush.
REQ-022 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-023 SHALL, on reset low, immediately clear all valid bits, tags, QP fields and blk_count, and drive in_ready, out_valid, stage_en and busy to 0.
REQ-024 SHALL, on reset low in mid-operation, discard in-flight blocks, which are never output; after reset, the first accepted block gets full latency.

Structure
REQ-025 SHALL place QP_MAX (51), the stage index constants and the per-stage record typedef (valid, tag, qp, qp_by6, qp_mod6) in the shared transform-coding package.
REQ-026 SHALL implement the QP clamp and div/mod-6 as sub-module tc_qp_split (combinational, 6-bit in, 4-bit quotient, 3-bit remainder).

Verification
REQ-027 SHALL cover: reset then one block, qp=28, tag=0x11, out_ready=1 -> stage_en walks 0001, 0010, 0100, 1000; out_valid in cycle 4 with tag 0x11; q_qp_by6=4, q_qp_mod6=4; blk_count=1.
REQ-028 SHALL cover: in_qp=63 -> out_qp=51, qp_by6=8, qp_mod6=3.
REQ-029 SHALL cover: 8 back-to-back blocks, tags 0-7, out_ready=1 -> 8 consecutive out_valid cycles, tags in order, in_ready constantly high.
REQ-030 SHALL cover: out_ready held low with 5 blocks offered -> exactly 4 accepted, in_ready low, outputs stable; releasing out_ready drains tags in order.
REQ-031 SHALL cover: flush asserted with 3 blocks in flight and in_valid high -> busy=0 next cycle, no out_valid, offered block not accepted.
REQ-032 SHALL cover: reset pulsed low asynchronously mid-stream -> outputs zero without a clock edge; blk_count=0.
